// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: one FSM sequences fetch/decode/execute/memory/writeback
// over a shared ready-handshaked memory port and drives all datapath enables and muxes.
module mips_multicycle_control #(
  parameter int EXT_ISA = 1,
  parameter int STRICT  = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             sign,
  output logic             sign_ext,
  output logic             shift,
  output logic             reg_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             jal,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  // Memory handshake: mem_req is held high until the cycle in which mem_ready is seen;
  // that cycle completes the transfer. mem_ready is ignored whenever mem_req is low.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam bit EXT = (EXT_ISA != 0);
  localparam bit STR = (STRICT != 0);

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] cnt;
  logic             retire;

  logic rt;
  logic d_add, d_sub, d_sll, d_srl, d_sra, d_jr, d_and, d_or, d_xor, d_slt;
  logic d_addi, d_lw, d_sw, d_beq, d_bne, d_j, d_jal;
  logic d_andi, d_ori, d_xori, d_slti, d_lui;
  logic r_alu, i_alu, legal, sign_d, sext_d, shift_d;

  assign rt     = (op == 6'h00);
  assign d_add  = rt && (funct == 6'h20);
  assign d_sub  = rt && (funct == 6'h22);
  assign d_sll  = rt && (funct == 6'h00);
  assign d_srl  = rt && (funct == 6'h02);
  assign d_sra  = rt && (funct == 6'h03);
  assign d_jr   = rt && (funct == 6'h08);
  assign d_and  = EXT && rt && (funct == 6'h24);
  assign d_or   = EXT && rt && (funct == 6'h25);
  assign d_xor  = EXT && rt && (funct == 6'h26);
  assign d_slt  = EXT && rt && (funct == 6'h2A);
  assign d_addi = (op == 6'h08);
  assign d_lw   = (op == 6'h23);
  assign d_sw   = (op == 6'h2B);
  assign d_beq  = (op == 6'h04);
  assign d_bne  = (op == 6'h05);
  assign d_j    = (op == 6'h02);
  assign d_jal  = (op == 6'h03);
  assign d_andi = EXT && (op == 6'h0C);
  assign d_ori  = EXT && (op == 6'h0D);
  assign d_xori = EXT && (op == 6'h0E);
  assign d_slti = EXT && (op == 6'h0A);
  assign d_lui  = EXT && (op == 6'h0F);

  assign r_alu   = d_add | d_sub | d_sll | d_srl | d_sra | d_and | d_or | d_xor | d_slt;
  assign i_alu   = d_addi | d_andi | d_ori | d_xori | d_slti | d_lui;
  assign legal   = r_alu | d_jr | i_alu | d_lw | d_sw | d_beq | d_bne | d_j | d_jal;
  assign sign_d  = d_add | d_sub | d_addi | d_slt | d_slti;
  assign sext_d  = d_addi | d_lw | d_sw | d_beq | d_bne | d_slti;
  assign shift_d = d_sll | d_srl | d_sra;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      cnt       <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    sign          = 1'b0;
    sign_ext      = 1'b0;
    shift         = 1'b0;
    reg_src       = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    jal           = 1'b0;
    illegal       = 1'b0;
    state         = 3'd0;
    instr_retired = '0;
    if (!reset) begin
      state         = cur_state;
      instr_retired = cnt;
      // Decode flags are meaningful once IR is loaded and stay valid until the next fetch.
      if (cur_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        sign     = sign_d;
        sign_ext = sext_d;
        shift    = shift_d;
      end
      case (cur_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            nxt_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (!legal) begin
            illegal   = 1'b1;
            nxt_state = STR ? S_HALT : S_FETCH;
          end else if (d_j || d_jal) begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = d_jal;
            jal       = d_jal;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else if (d_jr) begin
            pc_write  = 1'b1;
            pc_src    = 2'b11;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          if (d_beq || d_bne) begin
            pc_src    = 2'b01;
            pc_write  = (d_beq & zero) | (d_bne & ~zero);
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else if (d_lw || d_sw) begin
            alu_src_b = 2'b10;
            nxt_state = S_MEM;
          end else begin
            alu_src_b = i_alu ? 2'b10 : 2'b00;
            nxt_state = S_WB;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = d_sw;
          if (mem_ready) begin
            retire    = d_sw;
            nxt_state = d_sw ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_src   = d_lw;
          reg_dst   = r_alu;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
        S_HALT: nxt_state = S_HALT;
        default: nxt_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level reference model feeds an expected
// queue per cycle; a negedge monitor pops and compares against the selected DUT instance.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic        mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        sign, sign_ext, shift, reg_src, reg_dst, reg_write, jal, illegal;
    logic [2:0]  state;
    logic [31:0] cnt;
  } out_t;

  localparam int W = $bits(out_t);
  localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_BNE = 6,
                 C_J = 7, C_JAL = 8, C_JR = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       tgt, reset_v, zero, mem_ready;
  logic [5:0] op, funct;
  logic       rst_w [2];

  logic       mem_req_w [2], mem_write_w [2], iord_w [2], ir_write_w [2], pc_write_w [2];
  logic [1:0] pc_src_w [2], alu_src_b_w [2];
  logic       alu_src_a_w [2], sign_w [2], sign_ext_w [2], shift_w [2], reg_src_w [2];
  logic       reg_dst_w [2], reg_write_w [2], jal_w [2], illegal_w [2];
  logic [2:0] state_w [2];
  logic [31:0] cnt_w [2];
  out_t       act [2];

  // Instance 0: extended ISA, illegal = nop.  Instance 1: base ISA, illegal halts.
  // The instance not under test is held in reset.
  assign rst_w[0] = tgt ? 1'b1 : reset_v;
  assign rst_w[1] = tgt ? reset_v : 1'b1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_multicycle_control #(.EXT_ISA(g == 0 ? 1 : 0), .STRICT(g == 0 ? 0 : 1), .CNT_W(32)) u_dut (
      .clk(clk), .reset(rst_w[g]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req_w[g]), .mem_write(mem_write_w[g]), .iord(iord_w[g]),
      .ir_write(ir_write_w[g]), .pc_write(pc_write_w[g]), .pc_src(pc_src_w[g]),
      .alu_src_a(alu_src_a_w[g]), .alu_src_b(alu_src_b_w[g]), .sign(sign_w[g]),
      .sign_ext(sign_ext_w[g]), .shift(shift_w[g]), .reg_src(reg_src_w[g]),
      .reg_dst(reg_dst_w[g]), .reg_write(reg_write_w[g]), .jal(jal_w[g]),
      .illegal(illegal_w[g]), .state(state_w[g]), .instr_retired(cnt_w[g])
    );
    assign act[g] = {mem_req_w[g], mem_write_w[g], iord_w[g], ir_write_w[g], pc_write_w[g],
                     pc_src_w[g], alu_src_a_w[g], alu_src_b_w[g], sign_w[g], sign_ext_w[g],
                     shift_w[g], reg_src_w[g], reg_dst_w[g], reg_write_w[g], jal_w[g],
                     illegal_w[g], state_w[g], cnt_w[g]};
  end

  // Scoreboard
  logic [W-1:0] exp_q [$];
  string        nm_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  exp_cnt  = 0;
  out_t         mon_act;
  logic [W-1:0] mon_exp;
  string        mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_act = tgt ? act[1] : act[0];
      mon_exp = exp_q.pop_front();
      mon_nm  = nm_q.pop_front();
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mon_nm, mon_act, mon_exp);
      end
    end
  end

  function automatic out_t idle();
    out_t e;
    e = '0;
    e.cnt = exp_cnt;
    return e;
  endfunction

  // Reference classification straight from the ISA tables.
  function automatic void classify(input logic [5:0] o, input logic [5:0] f, input bit ext,
                                   output int cls, output bit sg, output bit se, output bit sh);
    cls = C_ILL; sg = 0; se = 0; sh = 0;
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h22: begin cls = C_R; sg = 1; end
        6'h00, 6'h02, 6'h03: begin cls = C_R; sh = 1; end
        6'h08: cls = C_JR;
        6'h24, 6'h25, 6'h26: if (ext) cls = C_R;
        6'h2A: if (ext) begin cls = C_R; sg = 1; end
        default: cls = C_ILL;
      endcase
    end else begin
      case (o)
        6'h08: begin cls = C_I; sg = 1; se = 1; end
        6'h23: begin cls = C_LW; se = 1; end
        6'h2B: begin cls = C_SW; se = 1; end
        6'h04: begin cls = C_BEQ; se = 1; end
        6'h05: begin cls = C_BNE; se = 1; end
        6'h02: cls = C_J;
        6'h03: cls = C_JAL;
        6'h0C, 6'h0D, 6'h0E, 6'h0F: if (ext) cls = C_I;
        6'h0A: if (ext) begin cls = C_I; sg = 1; se = 1; end
        default: cls = C_ILL;
      endcase
    end
  endfunction

  task automatic step(input out_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
  endtask

  task automatic apply_reset(input int n, input string nm);
    reset_v = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
      rand_bus();
      step('0, nm);
    end
    reset_v = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    out_t e;
    for (int i = 0; i < n; i++) begin
      rand_bus();
      e = idle(); e.state = 3'd5;
      step(e, "halt");
    end
  endtask

  // One instruction: fw/mw wait cycles in FETCH/MEM, optional reset while stalled in MEM.
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int fw, input int mw, input bit rst_in_mem, input string nm);
    int cls; bit sg, se, sh; out_t e, base;
    classify(o, f, (tgt == 1'b0), cls, sg, se, sh);
    for (int i = 0; i <= fw; i++) begin
      rand_bus();
      mem_ready = (i == fw);
      e = idle(); e.state = 3'd0; e.mem_req = 1; e.alu_src_b = 2'b01;
      if (i == fw) begin e.ir_write = 1; e.pc_write = 1; end
      step(e, {nm, "/fetch"});
    end
    op = o; funct = f; zero = 1'($urandom); mem_ready = 1'($urandom);
    base = idle(); base.sign = sg; base.sign_ext = se; base.shift = sh;
    e = base; e.state = 3'd1; e.alu_src_b = 2'b11;
    case (cls)
      C_J:   begin e.pc_write = 1; e.pc_src = 2'b10; end
      C_JAL: begin e.pc_write = 1; e.pc_src = 2'b10; e.reg_write = 1; e.jal = 1; end
      C_JR:  begin e.pc_write = 1; e.pc_src = 2'b11; end
      C_ILL: e.illegal = 1;
      default: ;
    endcase
    step(e, {nm, "/decode"});
    if (cls == C_ILL) return;
    if (cls == C_J || cls == C_JAL || cls == C_JR) begin exp_cnt++; return; end
    zero = (cls == C_BEQ || cls == C_BNE) ? z : 1'($urandom);
    mem_ready = 1'($urandom);
    e = base; e.state = 3'd2; e.alu_src_a = 1;
    e.alu_src_b = (cls == C_R || cls == C_BEQ || cls == C_BNE) ? 2'b00 : 2'b10;
    if (cls == C_BEQ || cls == C_BNE) begin
      e.pc_src = 2'b01;
      e.pc_write = (cls == C_BEQ) ? z : !z;
    end
    step(e, {nm, "/exec"});
    if (cls == C_BEQ || cls == C_BNE) begin exp_cnt++; return; end
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i < (rst_in_mem ? mw : mw + 1); i++) begin
        zero = 1'($urandom);
        mem_ready = !rst_in_mem && (i == mw);
        e = base; e.state = 3'd3; e.mem_req = 1; e.iord = 1; e.mem_write = (cls == C_SW);
        step(e, {nm, "/mem"});
      end
      if (rst_in_mem) begin
        mem_ready = 1'b0;
        reset_v = 1'b1;
        exp_cnt = 0;
        step('0, {nm, "/rst_in_mem"});
        reset_v = 1'b0;
        return;
      end
      if (cls == C_SW) begin exp_cnt++; return; end
    end
    rand_bus(); op = o; funct = f;
    e = base; e.state = 3'd4; e.reg_write = 1; e.reg_src = (cls == C_LW); e.reg_dst = (cls == C_R);
    step(e, {nm, "/wb"});
    exp_cnt++;
  endtask

  logic [11:0] ins_tbl [22] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03},
    {6'h00, 6'h08}, {6'h08, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00},
    {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00},
    {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h2A},
    {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0E, 6'h00}, {6'h0A, 6'h00}, {6'h0F, 6'h00}
  };

  task automatic rand_instr(input int max_idx, input bit allow_junk);
    logic [11:0] w;
    logic [5:0]  o, f;
    w = ins_tbl[$urandom_range(0, max_idx)];
    o = w[11:6];
    f = (o == 6'h00) ? w[5:0] : 6'($urandom);
    if (allow_junk && $urandom_range(0, 4) == 0) begin
      o = 6'($urandom); f = 6'($urandom);
    end
    do_instr(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, "rand");
  endtask

  initial begin
    tgt = 1'b0; reset_v = 1'b1; rand_bus();
    @(posedge clk); #1;
    apply_reset(2, "reset");
    do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, "add");
    do_instr(6'h23, 6'h05, 1'b0, 3, 2, 1'b0, "lw_wait");
    do_instr(6'h04, 6'h11, 1'b1, 0, 0, 1'b0, "beq_z1");
    do_instr(6'h04, 6'h11, 1'b0, 0, 0, 1'b0, "beq_z0");
    do_instr(6'h05, 6'h11, 1'b0, 0, 0, 1'b0, "bne_z0");
    do_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0, "jal");
    do_instr(6'h0D, 6'h3F, 1'b0, 0, 0, 1'b0, "ori_ext");
    do_instr(6'h00, 6'h3F, 1'b0, 1, 0, 1'b0, "ill_nop");
    do_instr(6'h2B, 6'h00, 1'b0, 1, 1, 1'b0, "sw");
    for (int i = 0; i < 60; i++) rand_instr(21, 1'b1);
    do_instr(6'h2B, 6'h00, 1'b0, 0, 2, 1'b1, "sw_rst");
    do_instr(6'h00, 6'h22, 1'b0, 0, 0, 1'b0, "sub_after_rst");

    tgt = 1'b1;
    apply_reset(2, "reset_strict");
    do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, "add_base");
    for (int i = 0; i < 15; i++) rand_instr(12, 1'b0);
    do_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0, "ori_base");
    halt_cycles(20);
    apply_reset(1, "reset_halt");
    do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, "add_post_halt");
    do_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, "j_post_halt");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
